// File: rtl/swat_pkg.sv
// Shared definitions for the SWAT_LE table loader: FSM state encoding and
// the positions of the control bits inside the 32-bit software register word.
package swat_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WRITE    = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  localparam int LE_BIT      = 31;
  localparam int AUTOINC_BIT = 30;

endpackage

// File: rtl/swreg_stable_sync.sv
// Two-flop capture of the software register word arriving from the OPB side.
// A word is only trusted once two consecutive samples agree, which filters a
// torn value that lasts a single cycle. The le bit of the last trusted word is
// remembered so that only a 0->1 transition of trusted le is reported.
module swreg_stable_sync
  import swat_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] word_i,
  output logic [31:0] word_o,
  output logic        stable_o,
  output logic        le_o,
  output logic        le_rise_o
);

  logic [31:0] r1_q;
  logic [31:0] r2_q;
  logic        prev_le_q;
  logic        prev_le_d;
  logic        stable;

  assign stable = (r1_q == r2_q);

  // prev_le only follows words that have proven stable
  always_comb begin
    prev_le_d = prev_le_q;
    if (stable) begin
      prev_le_d = r2_q[LE_BIT];
    end
  end

  // Capture pipeline and remembered le; reset clears le history so a level
  // still high after reset re-arms one write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r1_q      <= '0;
      r2_q      <= '0;
      prev_le_q <= 1'b0;
    end else begin
      r1_q      <= word_i;
      r2_q      <= r1_q;
      prev_le_q <= prev_le_d;
    end
  end

  assign word_o    = r2_q;
  assign stable_o  = stable;
  assign le_o      = r2_q[LE_BIT];
  assign le_rise_o = stable & r2_q[LE_BIT] & ~prev_le_q;

endmodule

// File: rtl/swat_le_table_loader.sv
// Consumes the SWAT_LE register word and turns each qualified rising edge of
// its le bit into exactly one valid/ready write into a lookup table. Tracks a
// completed-write counter and a sticky flag for edges lost while a write was
// still waiting for the table.
module swat_le_table_loader
  import swat_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       reg_data_in,
  input  logic              clr,
  output logic              tbl_valid,
  input  logic              tbl_ready,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [DATA_W-1:0] tbl_data,
  output logic              busy,
  output logic [CNT_W-1:0]  load_count,
  output logic              missed
);

  logic [31:0]       word;
  logic              stable;
  logic              le;
  logic              le_rise;
  logic              unused_word;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ai_q, ai_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              missed_q, missed_d;
  logic              skip_q, skip_d;
  logic              capture;
  logic              xfer;

  swreg_stable_sync u_sync (
    .clk_i     (user_clk),
    .rst_i     (user_rst),
    .word_i    (reg_data_in),
    .word_o    (word),
    .stable_o  (stable),
    .le_o      (le),
    .le_rise_o (le_rise)
  );

  // Bits between the autoinc flag and the address field carry no meaning here
  assign unused_word = &{1'b0, word};

  assign capture = (state_q == SETTLE) && stable && le;
  assign xfer    = (state_q == WRITE) && tbl_ready;

  // State register
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SETTLE demands one more stable cycle before committing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (le_rise)        state_d = SETTLE;
      SETTLE:   state_d = capture ? WRITE : IDLE;
      WRITE:    if (xfer)           state_d = WAIT_LOW;
      WAIT_LOW: if (stable && !le)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; tbl_valid falls together with an async reset
  always_comb begin
    tbl_valid = (state_q == WRITE);
    busy      = (state_q != IDLE);
  end

  // Captured write, pointer, counter and sticky flags. clr wins over any
  // coincident increment; a write already pending when clr arrives still
  // completes but is not counted (skip).
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    ai_d     = ai_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;
    skip_d   = skip_q;
    if (capture) begin
      ai_d   = word[AUTOINC_BIT];
      addr_d = word[AUTOINC_BIT] ? ptr_q : word[ADDR_W+DATA_W-1:DATA_W];
      data_d = word[DATA_W-1:0];
    end
    if (clr) begin
      ptr_d    = '0;
      cnt_d    = '0;
      missed_d = 1'b0;
    end else begin
      if (xfer && ai_q)                ptr_d    = ptr_q + ADDR_W'(1);
      if (xfer && !skip_q)             cnt_d    = cnt_q + CNT_W'(1);
      if ((state_q == WRITE) && le_rise) missed_d = 1'b1;
    end
    if (xfer) begin
      skip_d = 1'b0;
    end else if (clr && (state_q == WRITE)) begin
      skip_d = 1'b1;
    end
  end

  // Registered datapath and bookkeeping
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      ai_q     <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      ai_q     <= ai_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
      skip_q   <= skip_d;
    end
  end

  assign tbl_addr   = addr_q;
  assign tbl_data   = data_q;
  assign load_count = cnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_swat_le_table_loader.sv
// Directed bench for swat_le_table_loader: edge-triggered writes, latency,
// level-held le, autoinc wrap, back-pressure with a lost edge, torn word,
// async reset during a write and clr.
module tb_swat_le_table_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg_data_in;
  logic        clr;
  logic        tbl_valid;
  logic        tbl_ready;
  logic [8:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        busy;
  logic [15:0] load_count;
  logic        missed;

  int          vectors = 0;
  int          fails   = 0;
  int          wr_cnt  = 0;
  logic [8:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  int          wr_base;

  always #5 clk = ~clk;

  swat_le_table_loader #(.ADDR_W(9), .DATA_W(16), .CNT_W(16)) dut (
    .user_clk    (clk),
    .user_rst    (rst),
    .reg_data_in (reg_data_in),
    .clr         (clr),
    .tbl_valid   (tbl_valid),
    .tbl_ready   (tbl_ready),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .busy        (busy),
    .load_count  (load_count),
    .missed      (missed)
  );

  // Record every completed transfer seen on the table interface
  always @(posedge clk) begin
    if (!rst && tbl_valid && tbl_ready) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= tbl_addr;
      last_data <= tbl_data;
    end
  end

  function automatic logic [31:0] mk(input logic le, input logic ai,
                                     input logic [8:0] a, input logic [15:0] d);
    return {le, ai, 5'b0, a, d};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic ai, input logic [8:0] a, input logic [15:0] d);
    reg_data_in = mk(1'b1, ai, a, d);
    cyc(6);
    reg_data_in = mk(1'b0, ai, a, d);
    cyc(4);
  endtask

  initial begin
    rst         = 1'b1;
    clr         = 1'b0;
    tbl_ready   = 1'b1;
    reg_data_in = '0;
    @(negedge clk);
    cyc(2);
    // reset state
    chk("rst_valid", tbl_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", load_count, 0);
    chk("rst_missed", missed, 0);
    chk("rst_addr", tbl_addr, 0);
    chk("rst_data", tbl_data, 0);
    rst = 1'b0;
    cyc(3);

    // 1: single write, latency 4
    reg_data_in = mk(1'b1, 1'b0, 9'h005, 16'hBEEF);
    cyc(3);
    chk("t1_valid_early", tbl_valid, 0);
    cyc(1);
    chk("t1_valid", tbl_valid, 1);
    chk("t1_addr", tbl_addr, 9'h005);
    chk("t1_data", tbl_data, 16'hBEEF);
    cyc(1);
    chk("t1_valid_drop", tbl_valid, 0);
    chk("t1_count", load_count, 1);
    chk("t1_busy_waitlow", busy, 1);

    // 2: level held high gives one write; re-toggle gives a second
    cyc(100);
    chk("t2_writes_held", wr_cnt, 1);
    chk("t2_count_held", load_count, 1);
    reg_data_in = mk(1'b0, 1'b0, 9'h006, 16'h1234);
    cyc(5);
    chk("t2_idle", busy, 0);
    reg_data_in = mk(1'b1, 1'b0, 9'h006, 16'h1234);
    cyc(6);
    chk("t2_count", load_count, 2);
    chk("t2_addr", last_addr, 9'h006);
    chk("t2_data", last_data, 16'h1234);
    reg_data_in = mk(1'b0, 1'b0, 9'h006, 16'h1234);
    cyc(4);

    // 3: autoinc walks ptr from 0 up to 0x1FE, then wraps
    pulse(1'b1, 9'h0AA, 16'h0000);
    chk("t3_first_ptr", last_addr, 9'h000);
    for (int i = 1; i < 510; i++) pulse(1'b1, 9'h0AA, 16'(i));
    chk("t3_count_pre", load_count, 512);
    pulse(1'b1, 9'h0AA, 16'hA001);
    chk("t3_addr_1fe", last_addr, 9'h1FE);
    pulse(1'b1, 9'h0AA, 16'hA002);
    chk("t3_addr_1ff", last_addr, 9'h1FF);
    pulse(1'b1, 9'h0AA, 16'hA003);
    chk("t3_addr_wrap", last_addr, 9'h000);
    chk("t3_data_wrap", last_data, 16'hA003);
    chk("t3_count", load_count, 515);

    // 4: back-pressure with a lost edge
    chk("t4_missed_pre", missed, 0);
    wr_base   = wr_cnt;
    tbl_ready = 1'b0;
    reg_data_in = mk(1'b1, 1'b0, 9'h123, 16'hCAFE);
    cyc(4);
    chk("t4_valid", tbl_valid, 1);
    reg_data_in = mk(1'b0, 1'b0, 9'h123, 16'hCAFE);
    cyc(3);
    reg_data_in = mk(1'b1, 1'b0, 9'h055, 16'h1111);
    cyc(3);
    chk("t4_missed", missed, 1);
    chk("t4_addr_held", tbl_addr, 9'h123);
    chk("t4_data_held", tbl_data, 16'hCAFE);
    chk("t4_valid_held", tbl_valid, 1);
    cyc(10);
    chk("t4_no_write", wr_cnt, wr_base);
    tbl_ready = 1'b1;
    cyc(1);
    chk("t4_count", load_count, 516);
    chk("t4_data", last_data, 16'hCAFE);
    chk("t4_valid_drop", tbl_valid, 0);
    cyc(10);
    chk("t4_single", wr_cnt, wr_base + 1);
    chk("t4_missed_sticky", missed, 1);
    reg_data_in = mk(1'b0, 1'b0, 9'h055, 16'h1111);
    cyc(4);
    chk("t4_idle", busy, 0);

    // 5: one-cycle torn word with le=1
    wr_base = wr_cnt;
    reg_data_in = mk(1'b1, 1'b0, 9'h077, 16'h7777);
    cyc(1);
    reg_data_in = mk(1'b0, 1'b0, 9'h055, 16'h1111);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("t5_busy", busy, 0);
    end
    chk("t5_no_write", wr_cnt, wr_base);

    // 6: async reset during WRITE, then re-arm and clr
    tbl_ready   = 1'b0;
    reg_data_in = mk(1'b1, 1'b0, 9'h0C3, 16'h5A5A);
    cyc(4);
    chk("t6_valid_pre", tbl_valid, 1);
    wr_base = wr_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_async", tbl_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", load_count, 0);
    chk("t6_missed", missed, 0);
    chk("t6_addr", tbl_addr, 0);
    chk("t6_data", tbl_data, 0);
    @(negedge clk);
    rst       = 1'b0;
    tbl_ready = 1'b1;
    cyc(8);
    chk("t6_rearm_write", wr_cnt, wr_base + 1);
    chk("t6_rearm_count", load_count, 1);
    chk("t6_rearm_data", last_data, 16'h5A5A);
    reg_data_in = mk(1'b0, 1'b0, 9'h0C3, 16'h5A5A);
    cyc(4);
    for (int i = 0; i < 5; i++) pulse(1'b0, 9'(i), 16'(i));
    tbl_ready   = 1'b0;
    reg_data_in = mk(1'b1, 1'b0, 9'h010, 16'h0010);
    cyc(4);
    reg_data_in = mk(1'b0, 1'b0, 9'h010, 16'h0010);
    cyc(3);
    reg_data_in = mk(1'b1, 1'b0, 9'h010, 16'h0010);
    cyc(3);
    tbl_ready = 1'b1;
    cyc(1);
    reg_data_in = mk(1'b0, 1'b0, 9'h010, 16'h0010);
    cyc(4);
    chk("t6_count7", load_count, 7);
    chk("t6_missed1", missed, 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("t6_clr_count", load_count, 0);
    chk("t6_clr_missed", missed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
